// File: rtl/xrad_pkg.sv
// Shared types and constants for the XRAD accelerator front-end blocks.
package xrad_pkg;

   localparam int         XRAD_DATA_W  = 32;
   localparam logic [3:0] XRAD_CH_MASK = 4'b0111;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_IDLE = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/xrad_line_buffer.sv
// Two-row line buffer: lb0 holds the previous row, lb1 the row before that.
// Writing a column shifts the old lb0 entry into lb1; contents are never reset.
module xrad_line_buffer #(
   parameter int IMG_WIDTH = 8,
   parameter int DATA_W    = 32,
   parameter int COL_W     = $clog2(IMG_WIDTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [COL_W-1:0]  col,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_lb0,
   output logic [DATA_W-1:0] rd_lb1
);

   logic [DATA_W-1:0] lb0 [IMG_WIDTH];
   logic [DATA_W-1:0] lb1 [IMG_WIDTH];

   assign rd_lb0 = lb0[col];
   assign rd_lb1 = lb1[col];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         lb1[col] <= lb0[col];
         lb0[col] <= wr_data;
      end
   end

endmodule

// File: rtl/xrad_conv_window_feeder.sv
// Turns a raster pixel stream into 3-tap vertical columns for the serial MAC,
// holding each column until the accelerator's busy cycle has completed.
module xrad_conv_window_feeder
   import xrad_pkg::*;
#(
   parameter int IMG_WIDTH   = 8,
   parameter int DATA_W      = XRAD_DATA_W,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sof,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [DATA_W-1:0] pix_data,
   input  logic              pix_last,
   output logic [3:0]        ch_valid,
   output logic [DATA_W-1:0] ch_data0,
   output logic [DATA_W-1:0] ch_data1,
   output logic [DATA_W-1:0] ch_data2,
   output logic [DATA_W-1:0] ch_data3,
   input  logic              ai_busy,
   output logic [15:0]       win_count,
   output logic              err_line,
   output logic              err_timeout
);

   localparam int               COL_W    = $clog2(IMG_WIDTH);
   localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   feeder_state_t     state;
   logic [15:0]       row;
   logic [COL_W-1:0]  col;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              accept;
   logic              issue_win;
   logic [15:0]       cur_row;
   logic [COL_W-1:0]  cur_col;
   logic [DATA_W-1:0] lb0_q;
   logic [DATA_W-1:0] lb1_q;

   // Gating with rst keeps ready and valid low in the reset cycle itself.
   assign pix_ready = (state == IDLE) && !rst;
   assign accept    = pix_valid && pix_ready;
   assign ch_valid  = ((state == ISSUE) && !rst) ? XRAD_CH_MASK : 4'b0000;

   // sof re-bases the position before this pixel is written.
   assign cur_row   = sof ? 16'd0 : row;
   assign cur_col   = sof ? '0 : col;
   assign issue_win = accept && (cur_row >= 16'd2);

   xrad_line_buffer #(
      .IMG_WIDTH (IMG_WIDTH),
      .DATA_W    (DATA_W),
      .COL_W     (COL_W)
   ) u_line_buffer (
      .clk     (clk),
      .wr_en   (accept),
      .col     (cur_col),
      .wr_data (pix_data),
      .rd_lb0  (lb0_q),
      .rd_lb1  (lb1_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         row         <= 16'd0;
         col         <= '0;
         tmo_cnt     <= '0;
         win_count   <= 16'd0;
         err_line    <= 1'b0;
         err_timeout <= 1'b0;
         ch_data0    <= '0;
         ch_data1    <= '0;
         ch_data2    <= '0;
         ch_data3    <= '0;
      end else begin
         if (accept) begin
            if (issue_win) begin
               ch_data0 <= lb1_q;
               ch_data1 <= lb0_q;
               ch_data2 <= pix_data;
               ch_data3 <= DATA_W'({cur_row, 16'(cur_col)});
            end
            // A short line still advances the row so the stream keeps flowing.
            if ((cur_col == LAST_COL) || pix_last) begin
               col <= '0;
               row <= (cur_row == 16'hFFFF) ? cur_row : cur_row + 16'd1;
               if (pix_last && (cur_col != LAST_COL)) begin
                  err_line <= 1'b1;
               end
            end else begin
               col <= cur_col + 1'b1;
               row <= cur_row;
            end
         end

         case (state)
            IDLE: begin
               if (issue_win) begin
                  state   <= ISSUE;
                  tmo_cnt <= '0;
               end
            end
            ISSUE: begin
               state   <= WAIT_BUSY;
               tmo_cnt <= '0;
            end
            WAIT_BUSY: begin
               if (ai_busy) begin
                  state   <= WAIT_IDLE;
                  tmo_cnt <= '0;
               end else if (tmo_cnt == TMO_LAST) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
                  tmo_cnt     <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            WAIT_IDLE: begin
               // ai_done stays high after the first window, so the busy fall marks completion.
               if (!ai_busy) begin
                  win_count <= win_count + 16'd1;
                  state     <= IDLE;
                  tmo_cnt   <= '0;
               end else if (tmo_cnt == TMO_LAST) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
                  tmo_cnt     <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
